// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: SPI write FIFO with absolute priority over an optional block-fill engine.
// The fill engine is built only when VRAM_ARB_FILL_EN is defined.
module vram_write_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         PixClk5,
  input  logic                         nReset,
  input  logic                         SpiWrEn,
  input  logic [11:0]                  SpiWrAddr,
  input  logic [17:0]                  SpiWrData,
  input  logic                         FillStart,
  input  logic [11:0]                  FillAddr,
  input  logic [11:0]                  FillCount,
  input  logic [17:0]                  FillData,
  input  logic                         RamReady,
  output logic                         RamWrEn,
  output logic [11:0]                  RamWrAddr,
  output logic [17:0]                  RamWrData,
  output logic                         FillBusy,
  output logic                         FillDone,
  output logic                         Overflow,
  output logic [$clog2(FIFO_DEPTH):0]  FifoLevel
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [29:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q, wr_en_q;
  logic [11:0]   wr_addr_q;
  logic [17:0]   wr_data_q;
  logic          empty, full, pop, push, fill_wr;
  logic [11:0]   fill_addr;
  logic [17:0]   fill_data;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign pop   = RamReady && !empty;
  // A full FIFO still accepts a push when the head leaves at the same edge
  assign push  = SpiWrEn && (!full || pop);
  always_ff @(posedge PixClk5)
    if (push) mem_q[wr_q] <= {SpiWrAddr, SpiWrData};
  always_ff @(posedge PixClk5 or negedge nReset)
    if (!nReset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_q   <= ovf_q || (SpiWrEn && full && !pop);
      wr_en_q <= pop || fill_wr;
      if (pop) begin
        wr_addr_q <= mem_q[rd_q][29:18];
        wr_data_q <= mem_q[rd_q][17:0];
      end else if (fill_wr) begin
        wr_addr_q <= fill_addr;
        wr_data_q <= fill_data;
      end
    end
`ifdef VRAM_ARB_FILL_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} fill_state_t;
  fill_state_t state_q, state_d;
  logic [11:0] faddr_q, faddr_d, fcnt_q, fcnt_d;
  logic [17:0] fdata_q, fdata_d;
  always_ff @(posedge PixClk5 or negedge nReset)
    if (!nReset) begin
      state_q <= IDLE;
      faddr_q <= '0;
      fcnt_q  <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      faddr_q <= faddr_d;
      fcnt_q  <= fcnt_d;
      fdata_q <= fdata_d;
    end
  always_comb begin
    state_d = state_q;
    faddr_d = faddr_q;
    fcnt_d  = fcnt_q;
    fdata_d = fdata_q;
    fill_wr = 1'b0;
    unique case (state_q)
      IDLE:
        if (FillStart) begin
          state_d = FillCount != '0 ? RUN : DONE;
          faddr_d = FillAddr;
          fcnt_d  = FillCount;
          fdata_d = FillData;
        end
      RUN: begin
        fill_wr = RamReady && empty;
        if (fill_wr) begin
          faddr_d = faddr_q + 12'd1;
          fcnt_d  = fcnt_q - 12'd1;
          state_d = fcnt_q == 12'd1 ? DONE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign fill_addr = faddr_q;
  assign fill_data = fdata_q;
  assign FillBusy  = state_q != IDLE;
  assign FillDone  = state_q == DONE;
`else
  logic unused_fill;
  assign unused_fill = ^{FillStart, FillAddr, FillCount, FillData};
  assign fill_wr   = 1'b0;
  assign fill_addr = '0;
  assign fill_data = '0;
  assign FillBusy  = 1'b0;
  assign FillDone  = 1'b0;
`endif
  assign RamWrEn   = wr_en_q;
  assign RamWrAddr = wr_addr_q;
  assign RamWrData = wr_data_q;
  assign Overflow  = ovf_q;
  assign FifoLevel = cnt_q;
endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb_vram_write_arbiter: queue-based reference model compared every cycle, plus directed literal checks.
module tb_vram_write_arbiter;
  localparam int DEPTH = 4;
`ifdef VRAM_ARB_FILL_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic spi_en = 0, fill_start = 0, rdy = 0;
  logic [11:0] spi_addr = 0, fill_addr = 0, fill_cnt = 0;
  logic [17:0] spi_data = 0, fill_data = 0;
  logic wr_en, busy, done, ovf;
  logic [11:0] wr_addr;
  logic [17:0] wr_data;
  logic [2:0] lvl;
  int nvec = 0, nerr = 0, cyc_n = 0, done_cnt = 0;
  logic [11:0] cap_a[$];
  logic [17:0] cap_d[$];
  int cap_c[$];

  vram_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .PixClk5(clk), .nReset(rst_n), .SpiWrEn(spi_en), .SpiWrAddr(spi_addr), .SpiWrData(spi_data),
    .FillStart(fill_start), .FillAddr(fill_addr), .FillCount(fill_cnt), .FillData(fill_data),
    .RamReady(rdy), .RamWrEn(wr_en), .RamWrAddr(wr_addr), .RamWrData(wr_data),
    .FillBusy(busy), .FillDone(done), .Overflow(ovf), .FifoLevel(lvl));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue for the SPI buffer and plain counters for the fill job
  logic [29:0] m_q[$];
  logic [29:0] e;
  logic m_en = 0, m_ovf = 0, m_run = 0, m_done = 0, was_run, was_done;
  logic [11:0] m_addr = 0, m_fa = 0;
  logic [17:0] m_data = 0, m_fd = 0;
  int m_rem = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_en = 0; m_addr = 0; m_data = 0; m_ovf = 0; m_run = 0; m_done = 0;
    end else begin
      was_run = m_run;
      was_done = m_done;
      m_done = 0;
      m_en = 0;
      if (rdy && m_q.size() != 0) begin
        e = m_q.pop_front();
        m_en = 1; m_addr = e[29:18]; m_data = e[17:0];
      end else if (rdy && m_run) begin
        m_en = 1; m_addr = m_fa; m_data = m_fd;
        m_fa = m_fa + 12'd1;
        m_rem--;
        if (m_rem == 0) begin m_run = 0; m_done = 1; end
      end
      if (FE && !was_run && !was_done && fill_start) begin
        if (fill_cnt != 0) begin
          m_run = 1; m_fa = fill_addr; m_rem = int'(fill_cnt); m_fd = fill_data;
        end else m_done = 1;
      end
      if (spi_en) begin
        if (m_q.size() < DEPTH) m_q.push_back({spi_addr, spi_data});
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    cyc_n++;
    chk("RamWrEn", wr_en, m_en);
    chk("RamWrAddr", wr_addr, m_addr);
    chk("RamWrData", wr_data, m_data);
    chk("FillBusy", busy, m_run | m_done);
    chk("FillDone", done, m_done);
    chk("Overflow", ovf, m_ovf);
    chk("FifoLevel", lvl, m_q.size());
    if (wr_en) begin cap_a.push_back(wr_addr); cap_d.push_back(wr_data); cap_c.push_back(cyc_n); end
    if (done) done_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clr();
    cap_a.delete(); cap_d.delete(); cap_c.delete(); done_cnt = 0;
  endtask
  task automatic spi(input logic [11:0] a, input logic [17:0] d);
    spi_en = 1; spi_addr = a; spi_data = d;
    @(negedge clk);
    spi_en = 0;
  endtask
  task automatic fill(input logic [11:0] a, input logic [11:0] n, input logic [17:0] d);
    fill_start = 1; fill_addr = a; fill_cnt = n; fill_data = d;
    @(negedge clk);
    fill_start = 0;
  endtask

  initial begin
    logic [11:0] exp39 [4];
    int nfill, nspi, bad, first, last;
    exp39[0] = 12'hFFE; exp39[1] = 12'hFFF; exp39[2] = 12'h000; exp39[3] = 12'h001;
    #1 rst_n = 0;
    cyc(2);
    chk("rst_RamWrEn", wr_en, 0);
    chk("rst_FifoLevel", lvl, 0);
    chk("rst_Overflow", ovf, 0);
    rst_n = 1;
    rdy = 1;
    cyc(2);
    // single write, two-edge latency
    spi_en = 1; spi_addr = 12'h123; spi_data = 18'h24141;
    @(negedge clk);
    spi_en = 0;
    chk("lat_k", wr_en, 0);
    @(negedge clk);
    chk("lat_k1_en", wr_en, 1);
    chk("lat_k1_addr", wr_addr, 12'h123);
    chk("lat_k1_data", wr_data, 18'h24141);
    @(negedge clk);
    chk("lat_k2", wr_en, 0);
    // overflow with RamReady low
    rdy = 0;
    clr();
    for (int i = 0; i < 6; i++) spi(12'(i), 18'(18'h100 + i));
    chk("ovf_flag", ovf, 1);
    chk("ovf_level", lvl, 4);
    rdy = 1;
    cyc(8);
    chk("ovf_nwrites", cap_a.size(), 4);
    for (int i = 0; i < cap_a.size(); i++) chk("ovf_addr", cap_a[i], i);
    if (cap_c.size() == 4) chk("ovf_consec", cap_c[3] - cap_c[0], 3);
    // fill wrapping past 0xFFF
    clr();
    fill(12'hFFE, 12'd4, 18'h00720);
    cyc(10);
    chk("wrap_nwrites", cap_a.size(), FE ? 4 : 0);
    for (int i = 0; i < cap_a.size() && i < 4; i++) begin
      chk("wrap_addr", cap_a[i], exp39[i]);
      chk("wrap_data", cap_d[i], 18'h00720);
    end
    chk("wrap_done", done_cnt, FE ? 1 : 0);
    // 100-word fill pre-empted by one SPI write
    clr();
    fill(12'h000, 12'h064, 18'h2AAAA);
    cyc(20);
    spi(12'h050, 18'h3FFFF);
    cyc(100);
    nfill = 0; nspi = 0; bad = 0; first = 0; last = 0;
    for (int i = 0; i < cap_a.size(); i++)
      if (cap_d[i] == 18'h2AAAA) begin
        if (cap_a[i] != 12'(nfill)) bad++;
        if (nfill == 0) first = cap_c[i];
        last = cap_c[i];
        nfill++;
      end else if (cap_a[i] == 12'h050 && cap_d[i] == 18'h3FFFF) nspi++;
    chk("pre_nfill", nfill, FE ? 100 : 0);
    chk("pre_nspi", nspi, 1);
    chk("pre_seq", bad, 0);
    chk("pre_span", last - first, FE ? 100 : 0);
    chk("pre_done", done_cnt, FE ? 1 : 0);
    // zero-length fill
    clr();
    fill(12'h300, 12'd0, 18'h00001);
    cyc(4);
    chk("zero_nwrites", cap_a.size(), 0);
    chk("zero_done", done_cnt, FE ? 1 : 0);
    // reset mid-fill with two buffered entries
    fill(12'h200, 12'd20, 18'h00155);
    cyc(3);
    rdy = 0;
    spi(12'h7A1, 18'h11111);
    spi(12'h7A2, 18'h22222);
    chk("mid_level", lvl, 2);
    chk("mid_busy", busy, FE ? 1 : 0);
    #2 rst_n = 0;
    #1;
    chk("arst_en", wr_en, 0);
    chk("arst_addr", wr_addr, 0);
    chk("arst_data", wr_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_level", lvl, 0);
    cyc(2);
    rst_n = 1;
    clr();
    rdy = 1;
    cyc(30);
    chk("arst_nwrites", cap_a.size(), 0);
    chk("arst_nodone", done_cnt, 0);
    // full FIFO with simultaneous push and pop
    rdy = 0;
    clr();
    for (int i = 0; i < 4; i++) spi(12'(12'h400 + i), 18'(i));
    chk("full_level", lvl, 4);
    rdy = 1;
    spi(12'h404, 18'h4);
    chk("pp_level", lvl, 4);
    chk("pp_ovf", ovf, 0);
    cyc(8);
    chk("pp_nwrites", cap_a.size(), 5);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
